// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard / stall controller for the five-stage ThinPad
// CPU (second-generation load-use detector). Sits beside the ID stage and
// drives the hold (keep) and flush/bubble controls of PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB.
//
// Hazard classes, highest priority first:
//   FREEZE    mem_busy: everything holds, FSM and stall counter hold.
//   LOAD-USE  ID reads a register that the load in EX is about to write.
//             PC and IF/ID hold, a bubble goes into ID/EX, and the load
//             advances. Stall length is LOAD_LAT non-frozen cycles.
//   STRUCT    MEM owns the shared instruction RAM: PC holds, IF/ID flushed.
//   BRANCH    taken branch resolved in ID: IF/ID flushed.
//
// Parameters:
//   REG_W     register-address width
//   NULL_REG  register address meaning "no register" (never hazards)
//   LOAD_LAT  load-use stall cycles, legal range 1..15
//   CNT_W     width of the stall statistics counter
//
// Optional feature (compile-time macro HAZ_STATS_EN):
//   defined   -> stall_cycles counts cycles with pc_keep=1, saturating.
//   undefined -> stall_cycles is tied to 0, no counter is built.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active-low
//   id_rs1/_use      in   ID source register 1 and its read-enable
//   id_rs2/_use      in   ID source register 2 and its read-enable
//   ex_wreg          in   EX destination register
//   ex_wen           in   EX instruction writes a register
//   ex_is_load       in   EX instruction is a memory load
//   mem_if_conflict  in   MEM stage occupies the instruction RAM
//   mem_busy         in   data memory / UART not ready (freeze)
//   branch_taken     in   ID-resolved branch/jump taken
//   pc_keep..mem_keep out hold controls for PC and the four pipe registers
//   if_flush         out  load NOP into IF/ID
//   ex_bubble        out  load NOP into ID/EX
//   stall_cycles     out  stall statistics counter
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned       REG_W    = 4,
  parameter logic [REG_W-1:0]  NULL_REG = '1,
  parameter int unsigned       LOAD_LAT = 1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_use,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_use,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic             mem_if_conflict,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             pc_keep,
  output logic             if_keep,
  output logic             id_keep,
  output logic             ex_keep,
  output logic             mem_keep,
  output logic             if_flush,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_e;

  // Remaining LU_WAIT cycles loaded on entry; the first stall cycle is spent
  // in RUN, so LU_WAIT covers the other LOAD_LAT-1.
  localparam logic [3:0] LU_RELOAD = 4'(LOAD_LAT - 1);
  localparam bit         LU_MULTI  = (LOAD_LAT > 1);

  state_e     state_q, state_d;
  logic [3:0] lu_cnt_q, lu_cnt_d;

  // ---------------------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------------------
  logic rs1_match, rs2_match, lu_hit, lu_active;

  assign rs1_match = id_rs1_use && (id_rs1 == ex_wreg);
  assign rs2_match = id_rs2_use && (id_rs2 == ex_wreg);
  assign lu_hit    = ex_is_load && ex_wen && (ex_wreg != NULL_REG)
                     && (rs1_match || rs2_match);

  // Once in LU_WAIT the stall continues regardless of what EX now holds
  // (it is the bubble we inserted).
  assign lu_active = (state_q == LU_WAIT) || ((state_q == RUN) && lu_hit);

  // ---------------------------------------------------------------------------
  // Control decode (ungated by reset; gated at the ports below so that the
  // reset net never feeds register data paths)
  // ---------------------------------------------------------------------------
  logic pc_keep_raw, if_keep_raw, id_keep_raw, ex_keep_raw, mem_keep_raw;
  logic if_flush_raw, ex_bubble_raw;

  always_comb begin
    pc_keep_raw   = 1'b0;
    if_keep_raw   = 1'b0;
    id_keep_raw   = 1'b0;
    ex_keep_raw   = 1'b0;
    mem_keep_raw  = 1'b0;
    if_flush_raw  = 1'b0;
    ex_bubble_raw = 1'b0;
    if (mem_busy) begin
      pc_keep_raw  = 1'b1;
      if_keep_raw  = 1'b1;
      id_keep_raw  = 1'b1;
      ex_keep_raw  = 1'b1;
      mem_keep_raw = 1'b1;
    end else if (lu_active) begin
      // A structural conflict or taken branch arriving here is absorbed:
      // PC is already held and the branch re-resolves after the stall.
      pc_keep_raw   = 1'b1;
      if_keep_raw   = 1'b1;
      ex_bubble_raw = 1'b1;
    end else if (mem_if_conflict) begin
      pc_keep_raw  = 1'b1;
      if_flush_raw = 1'b1;
    end else if (branch_taken) begin
      if_flush_raw = 1'b1;
    end
  end

  assign pc_keep   = rst & pc_keep_raw;
  assign if_keep   = rst & if_keep_raw;
  assign id_keep   = rst & id_keep_raw;
  assign ex_keep   = rst & ex_keep_raw;
  assign mem_keep  = rst & mem_keep_raw;
  assign if_flush  = rst & if_flush_raw;
  assign ex_bubble = rst & ex_bubble_raw;

  // ---------------------------------------------------------------------------
  // Load-use FSM. Frozen cycles hold both state and count, so the stall
  // always lasts exactly LOAD_LAT non-frozen cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (!mem_busy) begin
      unique case (state_q)
        RUN: begin
          // With LOAD_LAT==1 the single stall cycle is this one; the bubble
          // entering EX clears lu_hit on its own next cycle.
          if (lu_hit && LU_MULTI) begin
            state_d  = LU_WAIT;
            lu_cnt_d = LU_RELOAD;
          end
        end
        LU_WAIT: begin
          lu_cnt_d = lu_cnt_q - 4'd1;
          if (lu_cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d  = RUN;
          lu_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall statistics
  // ---------------------------------------------------------------------------
`ifdef HAZ_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating: a long-running system must not wrap back to a small value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_keep_raw && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
